// File: rtl/col_readout.sv
// Column readout sequencer: precharge/evaluate/sense timing with read, CAM-search and MAC capture.
// Optional accumulator is built only when MAC_ACC_EN is defined; otherwise mode 10 is reserved.
module col_readout (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       read_bar,
  input  logic       mac_clr,
  input  logic [3:0] sa_out,
  input  logic [3:0] ml,
  output logic       preb,
  output logic       sa_en,
  output logic       busy,
  output logic       valid,
  output logic [3:0] rdata,
  output logic       hit,
  output logic [1:0] hit_addr,
  output logic [5:0] mac_sum
);

  typedef enum logic [2:0] {IDLE, PRE, EVAL, SENSE, DONE} state_t;

  localparam logic [1:0] MODE_READ = 2'b00;
  localparam logic [1:0] MODE_CAM  = 2'b01;
  localparam logic [1:0] MODE_MAC  = 2'b10;

  state_t     state_reg;
  logic [1:0] mode_reg;
  logic       preb_reg;
  logic       sa_en_reg;
  logic       busy_reg;
  logic       valid_reg;
  logic [3:0] rdata_reg;
  logic       hit_reg;
  logic [1:0] hit_addr_reg;

  logic       mode_ok;
  logic       launch;
  logic       capture;
  logic [1:0] lowest_idx;

`ifdef MAC_ACC_EN
  assign mode_ok = (mode != 2'b11);
`else
  assign mode_ok = (mode == MODE_READ) || (mode == MODE_CAM);
`endif

  assign launch  = (state_reg == IDLE) && start && cs && mode_ok;
  assign capture = (state_reg == SENSE) && cs;

  // Lowest-index matching row wins; descending scan lets the last hit overwrite.
  always_comb begin
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ml[i]) lowest_idx = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mode_reg     <= MODE_READ;
      preb_reg     <= 1'b1;
      sa_en_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      rdata_reg    <= 4'd0;
      hit_reg      <= 1'b0;
      hit_addr_reg <= 2'd0;
    end else begin
      preb_reg  <= 1'b1;
      sa_en_reg <= 1'b0;
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (launch) begin
            state_reg <= PRE;
            mode_reg  <= mode;
            preb_reg  <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        PRE: begin
          if (!cs) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= EVAL;
          end
        end
        EVAL: begin
          if (!cs) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= SENSE;
            sa_en_reg <= 1'b1;
          end
        end
        SENSE: begin
          if (!cs) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
            if (mode_reg == MODE_READ) rdata_reg <= sa_out;
            if (mode_reg == MODE_CAM) begin
              hit_reg      <= |ml;
              hit_addr_reg <= lowest_idx;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign preb     = preb_reg;
  assign sa_en    = sa_en_reg;
  assign busy     = busy_reg;
  assign valid    = valid_reg;
  assign rdata    = rdata_reg;
  assign hit      = hit_reg;
  assign hit_addr = hit_addr_reg;

`ifdef MAC_ACC_EN
  logic       read_bar_reg;
  logic [3:0] mac_bits;
  logic [2:0] pop;
  logic [6:0] sum_wide;
  logic [5:0] mac_sum_reg;
  logic       mac_capture;

  always_ff @(posedge clk) begin
    if (!rst_n)      read_bar_reg <= 1'b0;
    else if (launch) read_bar_reg <= read_bar;
  end

  // Complement sensing: XOR with polarity so popcount counts zeros when read_bar is set.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bits
      assign mac_bits[gi] = sa_out[gi] ^ read_bar_reg;
    end
  endgenerate

  always_comb begin
    pop = 3'd0;
    for (int i = 0; i < 4; i++) pop = pop + {2'b00, mac_bits[i]};
  end

  // A clear coinciding with a capture restarts the sum from this popcount.
  assign sum_wide    = (mac_clr ? 7'd0 : {1'b0, mac_sum_reg}) + {4'd0, pop};
  assign mac_capture = capture && (mode_reg == MODE_MAC);

  always_ff @(posedge clk) begin
    if (!rst_n)           mac_sum_reg <= 6'd0;
    else if (mac_capture) mac_sum_reg <= (sum_wide > 7'd63) ? 6'd63 : sum_wide[5:0];
    else if (mac_clr)     mac_sum_reg <= 6'd0;
  end

  assign mac_sum = mac_sum_reg;
`else
  logic unused_mac;
  assign unused_mac = ^{mac_clr, read_bar};
  assign mac_sum    = 6'd0;
`endif

endmodule

// File: tb/tb_col_readout.sv
// Directed bench for col_readout; MAC checks are compiled in when MAC_ACC_EN is defined.
module tb_col_readout;

  logic       clk = 1'b0;
  logic       rst_n, cs, start, read_bar, mac_clr;
  logic [1:0] mode;
  logic [3:0] sa_out, ml;
  logic       preb, sa_en, busy, valid, hit;
  logic [3:0] rdata;
  logic [1:0] hit_addr;
  logic [5:0] mac_sum;

  int tests = 0;
  int fails = 0;

  col_readout dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .start(start), .mode(mode),
    .read_bar(read_bar), .mac_clr(mac_clr), .sa_out(sa_out), .ml(ml),
    .preb(preb), .sa_en(sa_en), .busy(busy), .valid(valid), .rdata(rdata),
    .hit(hit), .hit_addr(hit_addr), .mac_sum(mac_sum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".preb"},     {7'd0, preb},     8'h01);
    chk({tag, ".sa_en"},    {7'd0, sa_en},    8'h00);
    chk({tag, ".busy"},     {7'd0, busy},     8'h00);
    chk({tag, ".valid"},    {7'd0, valid},    8'h00);
    chk({tag, ".rdata"},    {4'd0, rdata},    8'h00);
    chk({tag, ".hit"},      {7'd0, hit},      8'h00);
    chk({tag, ".hit_addr"}, {6'd0, hit_addr}, 8'h00);
    chk({tag, ".mac_sum"},  {2'd0, mac_sum},  8'h00);
  endtask

  // Launches an op and returns in DONE; scrambles mode/read_bar after launch to prove latching.
  task automatic op(input logic [1:0] m, input logic rb, input logic clr_at_sense);
    mode = m; read_bar = rb; start = 1'b1;
    tick();
    start = 1'b0; mode = ~m; read_bar = ~rb;
    tick();
    tick();
    mac_clr = clr_at_sense;
    tick();
    mac_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; start = 1'b0; mode = 2'b00;
    read_bar = 1'b0; mac_clr = 1'b0; sa_out = 4'd0; ml = 4'd0;
    tick(); tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Read timing: start sampled at edge 1
    cs = 1'b1; mode = 2'b00; sa_out = 4'b1010; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rd.c1.preb", {7'd0, preb}, 8'h00);
    chk("rd.c1.busy", {7'd0, busy}, 8'h01);
    tick();
    chk("rd.c2.preb",  {7'd0, preb},  8'h01);
    chk("rd.c2.sa_en", {7'd0, sa_en}, 8'h00);
    tick();
    chk("rd.c3.sa_en", {7'd0, sa_en}, 8'h01);
    chk("rd.c3.valid", {7'd0, valid}, 8'h00);
    tick();
    chk("rd.c4.valid", {7'd0, valid}, 8'h01);
    chk("rd.c4.rdata", {4'd0, rdata}, 8'h0a);
    sa_out = 4'b0000;
    tick();
    chk("rd.c5.busy",  {7'd0, busy},  8'h00);
    chk("rd.c5.valid", {7'd0, valid}, 8'h00);
    chk("rd.hold",     {4'd0, rdata}, 8'h0a);

    // CAM searches
    ml = 4'b0110;
    op(2'b01, 1'b0, 1'b0);
    chk("cam0110.valid", {7'd0, valid},    8'h01);
    chk("cam0110.hit",   {7'd0, hit},      8'h01);
    chk("cam0110.addr",  {6'd0, hit_addr}, 8'h01);
    chk("cam.rdata",     {4'd0, rdata},    8'h0a);
    tick();
    ml = 4'b0000;
    op(2'b01, 1'b0, 1'b0);
    chk("cam0000.hit",  {7'd0, hit},      8'h00);
    chk("cam0000.addr", {6'd0, hit_addr}, 8'h00);
    tick();
    ml = 4'b1000;
    op(2'b01, 1'b0, 1'b0);
    chk("cam1000.addr", {6'd0, hit_addr}, 8'h03);
    tick();
    ml = 4'b1011;
    op(2'b01, 1'b0, 1'b0);
    chk("cam1011.hit",  {7'd0, hit},      8'h01);
    chk("cam1011.addr", {6'd0, hit_addr}, 8'h00);
    tick();

    // Abort by cs=0 in EVAL
    sa_out = 4'b0101; mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    cs = 1'b0;
    tick();
    chk("abort.busy",  {7'd0, busy},  8'h00);
    chk("abort.valid", {7'd0, valid}, 8'h00);
    chk("abort.preb",  {7'd0, preb},  8'h01);
    tick();
    chk("abort.novalid", {7'd0, valid}, 8'h00);
    chk("abort.rdata",   {4'd0, rdata}, 8'h0a);
    cs = 1'b1;

    // Reset in SENSE
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("rstsense.sa_en", {7'd0, sa_en}, 8'h01);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("rst_in_sense");
    rst_n = 1'b1;
    tick();

    // Start while busy is ignored
    sa_out = 4'b1100; mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("busy_start.valid", {7'd0, valid}, 8'h01);
    chk("busy_start.rdata", {4'd0, rdata}, 8'h0c);
    tick();
    chk("busy_start.idle", {7'd0, busy}, 8'h00);
    tick();
    chk("busy_start.noop", {7'd0, busy}, 8'h00);

    // Reserved mode and deselected start
    mode = 2'b11; start = 1'b1;
    tick();
    chk("mode11.busy", {7'd0, busy}, 8'h00);
    mode = 2'b00; cs = 1'b0;
    tick();
    chk("cs0start.busy", {7'd0, busy}, 8'h00);
    start = 1'b0; cs = 1'b1;
    tick();

`ifdef MAC_ACC_EN
    mac_clr = 1'b1;
    tick();
    mac_clr = 1'b0;
    chk("mac.clr", {2'd0, mac_sum}, 8'd0);
    sa_out = 4'b1111;
    op(2'b10, 1'b0, 1'b0); chk("mac.op1", {2'd0, mac_sum}, 8'd4);  tick();
    op(2'b10, 1'b0, 1'b0); chk("mac.op2", {2'd0, mac_sum}, 8'd8);  tick();
    op(2'b10, 1'b0, 1'b0); chk("mac.op3", {2'd0, mac_sum}, 8'd12); tick();
    sa_out = 4'b0001;
    op(2'b10, 1'b1, 1'b0); chk("mac.rb", {2'd0, mac_sum}, 8'd15); tick();
    op(2'b00, 1'b0, 1'b0); chk("mac.read_hold", {2'd0, mac_sum}, 8'd15); tick();
    mac_clr = 1'b1;
    tick();
    mac_clr = 1'b0;
    chk("mac.clr2", {2'd0, mac_sum}, 8'd0);
    sa_out = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      op(2'b10, 1'b0, 1'b0);
      tick();
    end
    chk("mac.sum60", {2'd0, mac_sum}, 8'd60);
    op(2'b10, 1'b0, 1'b0); chk("mac.sat", {2'd0, mac_sum}, 8'd63); tick();
    op(2'b10, 1'b0, 1'b0); chk("mac.sat2", {2'd0, mac_sum}, 8'd63); tick();
    sa_out = 4'b0011;
    op(2'b10, 1'b0, 1'b1); chk("mac.clr_add", {2'd0, mac_sum}, 8'd2); tick();
`else
    sa_out = 4'b1111; mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mode10.busy", {7'd0, busy}, 8'h00);
    mac_clr = 1'b1;
    tick();
    mac_clr = 1'b0;
    chk("mode10.busy2",  {7'd0, busy},    8'h00);
    chk("nomac.mac_sum", {2'd0, mac_sum}, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
